// File: rtl/censor_word_ctrl_if.sv
// Bundled character stream, hash unit, blacklist lookup and status signals for censor_word_ctrl.
// slave is the controller's view; master is the surrounding environment's view.
interface censor_word_ctrl_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  hash_letter;
  logic        hash_is_alpha;
  logic [9:0]  hash_value;
  logic        hash_done;
  logic        lut_req;
  logic [9:0]  lut_addr;
  logic        lut_hit;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] censored_cnt;

  modport slave (
    input  in_data, in_valid, hash_value, hash_done, lut_hit, out_ready,
    output in_ready, hash_letter, hash_is_alpha, lut_req, lut_addr,
           out_data, out_valid, busy, censored_cnt
  );

  modport master (
    output in_data, in_valid, hash_value, hash_done, lut_hit, out_ready,
    input  in_ready, hash_letter, hash_is_alpha, lut_req, lut_addr,
           out_data, out_valid, busy, censored_cnt
  );
endinterface

// File: rtl/censor_word_ctrl.sv
// Buffers each word, hashes it, looks it up in a blacklist and re-emits it starred or verbatim.
// First char out 4 cycles after the delimiter; input stalls while a word drains, output holds under out_ready=0.
module censor_word_ctrl #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] STAR    = 8'h2A
) (
  input logic          clk,
  input logic          nrst,
  censor_word_ctrl_if.slave bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);

  localparam logic [2:0] COLLECT     = 3'd0;
  localparam logic [2:0] PASS        = 3'd1;
  localparam logic [2:0] FLUSH       = 3'd2;
  localparam logic [2:0] LOOKUP      = 3'd3;
  localparam logic [2:0] LOOKUP_WAIT = 3'd4;
  localparam logic [2:0] EMIT        = 3'd5;
  localparam logic [2:0] EMIT_DELIM  = 3'd6;

  logic [2:0]    state;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [LW-1:0] idx_nxt;
  logic          censor;
  logic          ovf;
  logic          run;
  logic [9:0]    hreg;
  logic [7:0]    delim;
  logic [15:0]   cnt;
  logic [7:0]    wbuf [MAX_LEN];

  logic          alpha;
  logic          full;
  logic          rdy;
  logic          ov;
  logic [7:0]    od;
  logic          take;
  logic          in_fire;
  logic          out_fire;

  always_comb begin
    alpha   = ((bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A)) ||
              ((bus.in_data >= 8'h61) && (bus.in_data <= 8'h7A));
    full    = (len == LW'(MAX_LEN));
    idx_nxt = idx + LW'(1);
  end

  // run stays low until the first edge after reset release, so in_ready cannot rise during reset
  always_comb begin
    rdy = 1'b0;
    case (state)
      COLLECT: rdy = run && !(full && alpha);
      PASS:    rdy = alpha ? bus.out_ready : 1'b1;
      default: rdy = 1'b0;
    endcase
  end

  always_comb begin
    ov = 1'b0;
    od = 8'h00;
    case (state)
      EMIT: begin
        ov = 1'b1;
        od = censor ? STAR : wbuf[idx[AW-1:0]];
      end
      EMIT_DELIM: begin
        ov = 1'b1;
        od = delim;
      end
      PASS: begin
        if (bus.in_valid && alpha) begin
          ov = 1'b1;
          od = bus.in_data;
        end
      end
      default: begin
        ov = 1'b0;
        od = 8'h00;
      end
    endcase
  end

  always_comb begin
    in_fire  = bus.in_valid && rdy;
    take     = (state == COLLECT) && in_fire && alpha;
    out_fire = ov && bus.out_ready;
  end

  assign bus.in_ready      = rdy;
  assign bus.out_valid     = ov;
  assign bus.out_data      = od;
  assign bus.hash_is_alpha = take;
  assign bus.hash_letter   = take ? bus.in_data : 8'h00;
  assign bus.lut_req       = (state == LOOKUP);
  assign bus.lut_addr      = hreg;
  assign bus.busy          = (state != COLLECT);
  assign bus.censored_cnt  = cnt;

  // Character storage carries no reset: len gates every read, so stale contents never reach the output.
  always_ff @(posedge clk) begin
    if (take) begin
      wbuf[len[AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= COLLECT;
      len    <= '0;
      idx    <= '0;
      censor <= 1'b0;
      ovf    <= 1'b0;
      hreg   <= '0;
      delim  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            if (alpha) begin
              len <= len + LW'(1);
            end else begin
              delim <= bus.in_data;
              state <= (len != '0) ? FLUSH : EMIT_DELIM;
            end
          end else if (bus.in_valid && alpha && full) begin
            // Over-long word: replay it verbatim, then stream the rest of it through PASS.
            ovf    <= 1'b1;
            censor <= 1'b0;
            idx    <= '0;
            state  <= EMIT;
          end
        end
        PASS: begin
          if (in_fire && !alpha) begin
            delim <= bus.in_data;
            state <= EMIT_DELIM;
          end
        end
        FLUSH: begin
          if (bus.hash_done) begin
            hreg  <= bus.hash_value;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          state <= LOOKUP_WAIT;
        end
        LOOKUP_WAIT: begin
          censor <= bus.lut_hit;
          if (bus.lut_hit && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
          end
          idx   <= '0;
          state <= EMIT;
        end
        EMIT: begin
          if (out_fire) begin
            if (idx_nxt == len) begin
              len   <= '0;
              idx   <= '0;
              ovf   <= 1'b0;
              state <= ovf ? PASS : EMIT_DELIM;
            end else begin
              idx <= idx_nxt;
            end
          end
        end
        EMIT_DELIM: begin
          if (bus.out_ready) begin
            state <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_censor_word_ctrl.sv
// Table-driven bench with a hash-unit/blacklist model and an output scoreboard for censor_word_ctrl.
module tb_censor_word_ctrl;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  censor_word_ctrl_if bus();

  censor_word_ctrl #(.MAX_LEN(16), .STAR(8'h2A)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    string stim;
    bit    hit;
    int    rmode;
    string exp;
    int    cnt;
    int    nreq;
    bit    chk_lat;
    string addr_word;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nreq     = 0;
  int first_ov = -1;
  int delim_cyc = -1;
  int rmode    = 0;
  bit hit_mode = 1'b0;
  bit chk_addr = 1'b0;
  logic [9:0] exp_addr = '0;
  logic [7:0] expq[$];
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  logic [9:0] hacc;
  logic       lut_hit_r;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  function automatic logic [9:0] model_hash(input string s);
    logic [9:0] h = '0;
    for (int i = 0; i < s.len(); i++) h = 10'(h * 10'd31 + 10'(s[i]));
    return h;
  endfunction

  function automatic vec_t mk(input string s, input bit hit, input int rm, input string e,
                              input int cnt, input int nr, input bit lat, input string aw);
    vec_t v;
    v.stim = s; v.hit = hit; v.rmode = rm; v.exp = e;
    v.cnt = cnt; v.nreq = nr; v.chk_lat = lat; v.addr_word = aw;
    return v;
  endfunction

  // External hash unit: accumulates letters, cleared once its value has been looked up.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) hacc <= '0;
    else if (bus.lut_req) hacc <= '0;
    else if (bus.hash_is_alpha) hacc <= 10'(hacc * 10'd31 + 10'(bus.hash_letter));
  end
  assign bus.hash_value = hacc;
  assign bus.hash_done  = bus.busy;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) lut_hit_r <= 1'b0;
    else lut_hit_r <= bus.lut_req & hit_mode;
  end
  assign bus.lut_hit = lut_hit_r;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge nrst) prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!nrst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("extra_out_char", bus.out_data, -1);
        end else begin
          chk("out_char", bus.out_data, expq.pop_front());
        end
      end
      if (bus.lut_req) begin
        nreq++;
        if (chk_addr) chk("lut_addr", bus.lut_addr, exp_addr);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send_char(input logic [7:0] c);
    bit ok = 1'b0;
    bus.in_data  = c;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        if (!is_alpha(c)) delim_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    if (!ok) chk("in_accept_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nrst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (!bus.busy && expq.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    repeat (5) @(negedge clk);
  endtask

  vec_t vecs[6];
  string long_a;
  string long_exp;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    long_a = "";
    for (int i = 0; i < 17; i++) long_a = {long_a, "a"};
    long_exp = {long_a, "."};

    vecs[0] = mk("ab ",            1'b1, 0, "** ",   1, 1, 1'b1, "ab");
    vecs[1] = mk("ab ",            1'b0, 0, "ab ",   0, 1, 1'b0, "ab");
    vecs[2] = mk("  x",            1'b1, 0, "  ",    0, 0, 1'b0, "");
    vecs[3] = mk(long_exp,         1'b1, 0, long_exp, 0, 0, 1'b0, "");
    vecs[4] = mk("cat!",           1'b1, 1, "***!",  1, 1, 1'b0, "");
    vecs[5] = mk("hi yo.",         1'b1, 0, "** **.", 2, 2, 1'b0, "");

    #12;
    chk("rst_in_ready",  bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_hash_is_alpha", bus.hash_is_alpha, 0);
    chk("rst_lut_req",   bus.lut_req, 0);
    chk("rst_lut_addr",  bus.lut_addr, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_cnt",       bus.censored_cnt, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      hit_mode  = vecs[v].hit;
      rmode     = vecs[v].rmode;
      nreq      = 0;
      first_ov  = -1;
      delim_cyc = -1;
      chk_addr  = (vecs[v].addr_word.len() > 0);
      exp_addr  = model_hash(vecs[v].addr_word);
      expq.delete();
      for (int i = 0; i < vecs[v].exp.len(); i++) expq.push_back(vecs[v].exp[i]);
      for (int i = 0; i < vecs[v].stim.len(); i++) send_char(vecs[v].stim[i]);
      drain();
      chk($sformatf("v%0d_queue_left", v), expq.size(), 0);
      chk($sformatf("v%0d_censored_cnt", v), bus.censored_cnt, vecs[v].cnt);
      chk($sformatf("v%0d_lut_req_count", v), nreq, vecs[v].nreq);
      chk($sformatf("v%0d_busy_idle", v), bus.busy, 0);
      if (vecs[v].chk_lat) chk("first_out_latency", first_ov - delim_cyc, 4);
    end

    // Reset pulsed while "dog " sits stalled in EMIT.
    do_reset();
    hit_mode = 1'b1;
    rmode    = 2;
    chk_addr = 1'b0;
    expq.delete();
    send_char("d"); send_char("o"); send_char("g"); send_char(" ");
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge clk);
        if (bus.out_valid && bus.busy) seen = 1'b1;
      end
      chk("dog_reached_emit", seen, 1);
    end
    chk("dog_cnt_before_rst", bus.censored_cnt, 1);
    #1;
    nrst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data",  bus.out_data, 0);
    chk("midrst_busy",      bus.busy, 0);
    chk("midrst_in_ready",  bus.in_ready, 0);
    chk("midrst_cnt",       bus.censored_cnt, 0);
    @(posedge clk);
    #1;
    nrst  = 1'b1;
    rmode = 0;
    #1;
    chk("release_in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("release_in_ready_after_edge", bus.in_ready, 1);
    repeat (20) @(negedge clk);
    chk("post_rst_cnt",  bus.censored_cnt, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_queue", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/censor_word_ctrl.md
CENSOR_WORD_CTRL -- requirements
Module: censor_word_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum buffered word length in characters, range 2..64.
REQ-002 Parameter STAR, default 8'h2A: replacement character emitted for each letter of a censored word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 nrst  input  1  reset; asynchronous, active-low.
REQ-005 in_data  input  8  incoming ASCII character.
REQ-006 in_valid / in_ready  input / output  1  input handshake; a character transfers on a cycle with both high.
REQ-007 hash_letter  output  8  character fed to the external hash unit.
REQ-008 hash_is_alpha  output  1  hash unit update strobe.
REQ-009 hash_value  input  10  hash unit result.
REQ-010 hash_done  input  1  hash unit ready flag.
REQ-011 lut_req  output  1  one-cycle blacklist lookup strobe.
REQ-012 lut_addr  output  10  blacklist lookup address.
REQ-013 lut_hit  input  1  blacklist result, valid the cycle after lut_req.
REQ-014 out_data  output  8  outgoing character.
REQ-015 out_valid / out_ready  output / input  1  output handshake.
REQ-016 busy  output  1  high in any state other than COLLECT.
REQ-017 censored_cnt  output  16  count of censored words, saturating at 16'hFFFF.

Function
REQ-018 Alpha means in_data in 8'h41..8'h5A or 8'h61..8'h7A; every other value is a delimiter.
REQ-019 States: COLLECT, PASS, FLUSH, LOOKUP, LOOKUP_WAIT, EMIT, EMIT_DELIM.
REQ-020 in_ready is high only in COLLECT and PASS, except in COLLECT when len==MAX_LEN and in_data is alpha.
REQ-021 In COLLECT, an accepted alpha char is written to buf[len], len increments, and in that cycle hash_letter=in_data and hash_is_alpha=1.
REQ-022 In all other cycles hash_is_alpha=0 and hash_letter=8'h00.
REQ-023 In COLLECT, an accepted delimiter is stored in delim; the next state is FLUSH if len>0, otherwise EMIT_DELIM.
REQ-024 In COLLECT, an alpha char offered with len==MAX_LEN is not accepted; the word is marked uncensored and the next state is EMIT.
  - After EMIT drains, the next state is PASS instead of EMIT_DELIM.
REQ-025 In PASS, an accepted alpha char is copied to the output (out_valid=1, out_data=in_data), with in_ready=out_ready.
REQ-026 In PASS, an accepted delimiter goes to delim, and the next state is EMIT_DELIM.
REQ-027 FLUSH holds until hash_done=1, then latches hash_value into hreg and goes to LOOKUP.
REQ-028 LOOKUP drives lut_req=1 and lut_addr=hreg for exactly one cycle, then goes to LOOKUP_WAIT.
REQ-029 Outside LOOKUP, lut_req=0; lut_addr holds hreg.
REQ-030 LOOKUP_WAIT latches censor=lut_hit and increments censored_cnt when lut_hit=1 (saturating), then goes to EMIT with idx=0.
REQ-031 EMIT behaviour:
  - out_valid=1 and out_data = censor ? STAR : buf[idx].
  - idx advances only on an out_valid&&out_ready cycle.
  - After idx==len-1 transfers, len clears and the next state is EMIT_DELIM (or PASS per REQ-024).
REQ-032 EMIT_DELIM drives out_valid=1 and out_data=delim; on transfer, the next state is COLLECT.
REQ-033 out_valid and out_data are stable while out_valid=1 and out_ready=0.
REQ-034 Latency: with out_ready=1, lut_hit timely and hash_done rising the cycle after the delimiter, the first output char has out_valid=1 exactly 4 cycles after the delimiter transfer cycle.
REQ-035 No input is accepted between the delimiter transfer and completion of EMIT_DELIM.

Reset
REQ-036 While nrst=0, all outputs are held at 0, the state is COLLECT, and len, idx, censor, hreg, delim and censored_cnt are 0.
REQ-037 Asserting nrst mid-word or mid-emit discards the buffered chars; no partial output follows deassertion.
REQ-038 in_ready rises on the first clk edge after nrst deasserts.

Verification
REQ-039 The bench shall cover:
  - "ab " with lut_hit=1 always, out_ready=1 -> out "** ", censored_cnt=1, first out_valid 4 cycles after the ' ' transfer.
  - "ab " with lut_hit=0 -> out "ab ", censored_cnt=0, lut_addr equals the model hash of "ab".
  - "  x" (two spaces then x) -> two spaces pass straight through with no lut_req; then x is buffered.
  - 17 'a' then '.' with MAX_LEN=16, lut_hit=1 -> 17 'a' then '.' uncensored, no lut_req, censored_cnt=0.
  - "cat!" with out_ready toggling 1/0 each cycle -> out "***!", data stable during stalls, no duplicates or drops.
  - nrst pulsed low during EMIT of "dog " -> outputs 0 immediately; after release in_ready=1, no residual chars, censored_cnt=0.
